// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, optional zero pad, FCS and inter-frame gap.
// Define ETH_TX_PAD_EN to pad short payloads with zeros up to MIN_FRAME bytes before the FCS.
module eth_tx_framer #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_FRAME = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       tx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} state_e;

    state_e      state_q;
    logic [2:0]  pre_cnt_q;
    logic [1:0]  fcs_cnt_q;
    logic [7:0]  ifg_cnt_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [7:0]  crc_din;
    logic        crc_en;
    logic        take;

`ifdef ETH_TX_PAD_EN
    logic [5:0] len_q;
    logic [5:0] len_d;
    logic [6:0] len_inc;
    assign len_inc = {1'b0, len_q} + 7'd1;
    assign len_d   = (len_inc >= 7'(MIN_FRAME)) ? 6'(MIN_FRAME) : len_inc[5:0];
`endif

    // Reflected CRC-32 (poly 0x04C11DB7), one byte per enabled cycle.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // The SFD slot's strobe already pulls the first payload byte, so SFD accepts like DATA.
    assign s_ready = tx_rdy && (state_q == StSfd || state_q == StData);
    assign take    = s_ready && s_valid;
    assign busy    = (state_q != StIdle);

    always_comb begin
        crc_en  = take;
        crc_din = s_data;
`ifdef ETH_TX_PAD_EN
        if (tx_rdy && state_q == StPad) begin
            crc_en  = 1'b1;
            crc_din = 8'h00;
        end
`endif
    end

    assign crc_d = crc_en ? crc_step(crc_q, crc_din) : crc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pre_cnt_q  <= '0;
            fcs_cnt_q  <= '0;
            ifg_cnt_q  <= '0;
            crc_q      <= '1;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
`ifdef ETH_TX_PAD_EN
            len_q      <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            crc_q      <= (state_q == StIdle) ? '1 : crc_d;
`ifdef ETH_TX_PAD_EN
            if (state_q == StIdle) len_q <= '0;
`endif
            if (tx_rdy) begin
                unique case (state_q)
                    StIdle: begin
                        tx_er <= 1'b0;
                        if (s_valid) begin
                            tx_data   <= 8'h55;
                            tx_en     <= 1'b1;
                            pre_cnt_q <= 3'd1;
                            state_q   <= StPre;
                        end else begin
                            tx_data <= 8'h00;
                            tx_en   <= 1'b0;
                        end
                    end
                    StPre: begin
                        if (pre_cnt_q == 3'd7) begin
                            tx_data <= 8'hD5;
                            state_q <= StSfd;
                        end else begin
                            tx_data   <= 8'h55;
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end
                    StSfd, StData: begin
                        if (s_valid) begin
                            tx_data   <= s_data;
                            state_q   <= StData;
`ifdef ETH_TX_PAD_EN
                            len_q     <= len_d;
`endif
                            if (s_last) begin
                                fcs_cnt_q <= '0;
                                state_q   <= StFcs;
`ifdef ETH_TX_PAD_EN
                                if (len_inc < 7'(MIN_FRAME)) state_q <= StPad;
`endif
                            end
                        end else begin
                            // Source starved mid-frame: poison this slot and skip the FCS.
                            tx_data   <= 8'h00;
                            tx_er     <= 1'b1;
                            underrun  <= 1'b1;
                            ifg_cnt_q <= '0;
                            state_q   <= StIfg;
                        end
                    end
`ifdef ETH_TX_PAD_EN
                    StPad: begin
                        tx_data <= 8'h00;
                        len_q   <= len_d;
                        if (len_inc >= 7'(MIN_FRAME)) begin
                            fcs_cnt_q <= '0;
                            state_q   <= StFcs;
                        end
                    end
`endif
                    StFcs: begin
                        tx_data   <= ~crc_q[{fcs_cnt_q, 3'b000} +: 8];
                        fcs_cnt_q <= fcs_cnt_q + 2'd1;
                        if (fcs_cnt_q == 2'd3) begin
                            frame_done <= 1'b1;
                            ifg_cnt_q  <= '0;
                            state_q    <= StIfg;
                        end
                    end
                    StIfg: begin
                        tx_data   <= 8'h00;
                        tx_en     <= 1'b0;
                        tx_er     <= 1'b0;
                        ifg_cnt_q <= ifg_cnt_q + 8'd1;
                        if (ifg_cnt_q == 8'(IFG_BYTES - 1)) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule
